// File: rtl/ifetch_data_stage.sv
// Second I-fetch stage: tag compare against a launch-time snapshot, hit forwarding to decode and miss reporting.
// Owns the L1I tag/valid arrays and per-set round-robin pointers; 1-cycle lookup, hits hold under decode stall.
module ifetch_data_stage #(
   parameter int NUM_WARP_PER_CORE_LOG     = 2,
   parameter int ADDR_WIDTH                = 32,
   parameter int L1_CACHE_NUM_SETS         = 64,
   parameter int L1_CACHE_NUM_SETS_LOG     = 6,
   parameter int L1_CACHE_NUM_WAYS         = 4,
   parameter int L1_CACHE_NUM_WAYS_LOG     = 2,
   parameter int CACHE_LINE_BYTE_WIDTH_LOG = 6,
   parameter int TAG_W = ADDR_WIDTH - L1_CACHE_NUM_SETS_LOG - CACHE_LINE_BYTE_WIDTH_LOG
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        ift_to_ifd_valid,
   input  logic [ADDR_WIDTH+NUM_WARP_PER_CORE_LOG-1:0] ift_to_ifd_bus,
   input  logic                                        ift_to_icache_fetch_en,
   input  logic [L1_CACHE_NUM_SETS_LOG-1:0]            ift_to_icache_fetch_set_idx,
   output logic                                        ifd_allowin,
   output logic                                        ifd_cache_miss,
   output logic                                        ifd_near_miss,
   output logic [NUM_WARP_PER_CORE_LOG-1:0]            ifd_cache_miss_warp_idx,
   output logic                                        ifd_to_l2i_miss_en,
   output logic [ADDR_WIDTH-1:0]                       ifd_to_l2i_miss_addr,
   input  logic                                        l2i_to_ifd_fill_en,
   input  logic [L1_CACHE_NUM_SETS_LOG-1:0]            l2i_to_ifd_fill_set_idx,
   input  logic [TAG_W-1:0]                            l2i_to_ifd_fill_tag,
   output logic                                        ifd_to_idata_rd_en,
   output logic [L1_CACHE_NUM_SETS_LOG-1:0]            ifd_to_idata_rd_set_idx,
   output logic [L1_CACHE_NUM_WAYS_LOG-1:0]            ifd_to_idata_rd_way_idx,
   input  logic                                        dcd_allowin,
   output logic                                        ifd_to_dcd_valid,
   output logic [ADDR_WIDTH+NUM_WARP_PER_CORE_LOG-1:0] ifd_to_dcd_bus,
   input  logic                                        wb_rollback_en,
   input  logic [NUM_WARP_PER_CORE_LOG-1:0]            wb_rollback_warp_idx
);

   localparam int WL = NUM_WARP_PER_CORE_LOG;
   localparam int SL = L1_CACHE_NUM_SETS_LOG;
   localparam int YL = L1_CACHE_NUM_WAYS_LOG;
   localparam int LL = CACHE_LINE_BYTE_WIDTH_LOG;
   localparam int NS = L1_CACHE_NUM_SETS;
   localparam int NW = L1_CACHE_NUM_WAYS;
   localparam logic [YL-1:0] LAST_WAY = YL'(NW - 1);

   // tag/valid arrays and replacement pointers
   logic [NW-1:0]    arr_vld_q [NS];
   logic [NW-1:0]    arr_vld_d [NS];
   logic [TAG_W-1:0] arr_tag_q [NS][NW];
   logic [TAG_W-1:0] arr_tag_d [NS][NW];
   logic [YL-1:0]    rr_ptr_q  [NS];
   logic [YL-1:0]    rr_ptr_d  [NS];

   // stage registers
   logic                  ifd_valid_q, ifd_valid_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [WL-1:0]         warp_q, warp_d;
   logic [SL-1:0]         snap_set_q, snap_set_d;
   logic [NW-1:0]         snap_vld_q, snap_vld_d;
   logic [TAG_W-1:0]      snap_tag_q [NW];
   logic [TAG_W-1:0]      snap_tag_d [NW];
   logic                  fill_race_q, fill_race_d;
   logic                  race_match_q, race_match_d;
   logic [YL-1:0]         race_way_q, race_way_d;
   logic [TAG_W-1:0]      race_tag_q, race_tag_d;

   logic                  launch;
   logic [ADDR_WIDTH-1:0] in_pc;
   logic [WL-1:0]         in_warp;
   logic [YL-1:0]         fill_way;
   logic [TAG_W-1:0]      pc_tag;
   logic [SL-1:0]         pc_set;
   logic [NW-1:0]         way_match;
   logic                  hit;
   logic [YL-1:0]         hit_way;
   logic                  fill_hits_pc;
   logic                  fill_match;
   logic                  squash;

   assign in_pc    = ift_to_ifd_bus[WL +: ADDR_WIDTH];
   assign in_warp  = ift_to_ifd_bus[WL-1:0];
   assign launch   = ift_to_ifd_valid && ifd_allowin;
   assign fill_way = rr_ptr_q[l2i_to_ifd_fill_set_idx];
   assign pc_tag   = pc_q[ADDR_WIDTH-1 -: TAG_W];
   assign pc_set   = pc_q[LL +: SL];

   // The way overwritten by a fill racing the launch is stale in the snapshot, so it cannot hit.
   always_comb begin
      way_match = '0;
      hit       = 1'b0;
      hit_way   = '0;
      for (int w = 0; w < NW; w++) begin
         way_match[w] = snap_vld_q[w] && (snap_tag_q[w] == pc_tag) &&
                        !(fill_race_q && (race_way_q == YL'(w)));
      end
      for (int w = NW - 1; w >= 0; w--) begin
         if (way_match[w]) begin
            hit     = 1'b1;
            hit_way = YL'(w);
         end
      end
   end

   assign fill_hits_pc = l2i_to_ifd_fill_en && (l2i_to_ifd_fill_set_idx == pc_set) &&
                         (l2i_to_ifd_fill_tag == pc_tag);
   assign fill_match   = fill_hits_pc || race_match_q;
   assign squash       = wb_rollback_en && (wb_rollback_warp_idx == warp_q);

   assign ifd_to_dcd_valid        = ifd_valid_q && hit && !squash;
   assign ifd_near_miss           = ifd_valid_q && !hit && fill_match && !squash;
   assign ifd_cache_miss          = ifd_valid_q && !hit && !fill_match && !squash;
   assign ifd_to_l2i_miss_en      = ifd_cache_miss;
   assign ifd_to_l2i_miss_addr    = {pc_q[ADDR_WIDTH-1:LL], {LL{1'b0}}};
   assign ifd_cache_miss_warp_idx = warp_q;
   assign ifd_allowin             = !ifd_valid_q || !ifd_to_dcd_valid || dcd_allowin;
   assign ifd_to_idata_rd_en      = ifd_to_dcd_valid && dcd_allowin;
   assign ifd_to_idata_rd_set_idx = pc_set;
   assign ifd_to_idata_rd_way_idx = hit_way;
   assign ifd_to_dcd_bus          = {pc_q, warp_q};

   always_comb begin
      ifd_valid_d  = ifd_valid_q;
      pc_d         = pc_q;
      warp_d       = warp_q;
      snap_set_d   = snap_set_q;
      snap_vld_d   = snap_vld_q;
      snap_tag_d   = snap_tag_q;
      fill_race_d  = 1'b0;
      race_match_d = 1'b0;
      race_way_d   = race_way_q;
      race_tag_d   = race_tag_q;
      if (ifd_allowin) begin
         ifd_valid_d = ift_to_ifd_valid;
      end
      if (launch) begin
         pc_d       = in_pc;
         warp_d     = in_warp;
         snap_set_d = ift_to_icache_fetch_set_idx;
         snap_vld_d = ift_to_icache_fetch_en ? arr_vld_q[ift_to_icache_fetch_set_idx] : '0;
         for (int w = 0; w < NW; w++) begin
            snap_tag_d[w] = arr_tag_q[ift_to_icache_fetch_set_idx][w];
         end
         fill_race_d  = l2i_to_ifd_fill_en &&
                        (l2i_to_ifd_fill_set_idx == ift_to_icache_fetch_set_idx);
         race_match_d = fill_race_d && (l2i_to_ifd_fill_tag == in_pc[ADDR_WIDTH-1 -: TAG_W]);
         race_way_d   = fill_way;
         race_tag_d   = l2i_to_ifd_fill_tag;
      end else if (ifd_valid_q) begin
         // Fold the launch-cycle fill in first, then write through the current one.
         if (fill_race_q) begin
            snap_vld_d[race_way_q] = 1'b1;
            snap_tag_d[race_way_q] = race_tag_q;
         end
         if (l2i_to_ifd_fill_en && (l2i_to_ifd_fill_set_idx == snap_set_q)) begin
            snap_vld_d[fill_way] = 1'b1;
            snap_tag_d[fill_way] = l2i_to_ifd_fill_tag;
         end
      end
   end

   always_comb begin
      arr_vld_d = arr_vld_q;
      arr_tag_d = arr_tag_q;
      rr_ptr_d  = rr_ptr_q;
      if (l2i_to_ifd_fill_en) begin
         arr_vld_d[l2i_to_ifd_fill_set_idx][fill_way] = 1'b1;
         arr_tag_d[l2i_to_ifd_fill_set_idx][fill_way] = l2i_to_ifd_fill_tag;
         rr_ptr_d[l2i_to_ifd_fill_set_idx] = (fill_way == LAST_WAY) ? '0 : fill_way + YL'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifd_valid_q  <= 1'b0;
         pc_q         <= '0;
         warp_q       <= '0;
         snap_set_q   <= '0;
         snap_vld_q   <= '0;
         fill_race_q  <= 1'b0;
         race_match_q <= 1'b0;
         race_way_q   <= '0;
         race_tag_q   <= '0;
         for (int w = 0; w < NW; w++) begin
            snap_tag_q[w] <= '0;
         end
         for (int s = 0; s < NS; s++) begin
            arr_vld_q[s] <= '0;
            rr_ptr_q[s]  <= '0;
         end
      end else begin
         ifd_valid_q  <= ifd_valid_d;
         pc_q         <= pc_d;
         warp_q       <= warp_d;
         snap_set_q   <= snap_set_d;
         snap_vld_q   <= snap_vld_d;
         fill_race_q  <= fill_race_d;
         race_match_q <= race_match_d;
         race_way_q   <= race_way_d;
         race_tag_q   <= race_tag_d;
         snap_tag_q   <= snap_tag_d;
         arr_vld_q    <= arr_vld_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   // Tags are qualified by the valid bits, so they need no reset.
   always_ff @(posedge clk) begin
      arr_tag_q <= arr_tag_d;
   end

endmodule

// File: tb/tb_ifetch_data_stage.sv
// Bench for ifetch_data_stage: directed scenarios plus randomized lookups against a line-level cache model.
module tb_ifetch_data_stage;
   localparam int TW = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ift_to_ifd_valid;
   logic [33:0] ift_to_ifd_bus;
   logic        ift_to_icache_fetch_en;
   logic [5:0]  ift_to_icache_fetch_set_idx;
   logic        ifd_allowin;
   logic        ifd_cache_miss;
   logic        ifd_near_miss;
   logic [1:0]  ifd_cache_miss_warp_idx;
   logic        ifd_to_l2i_miss_en;
   logic [31:0] ifd_to_l2i_miss_addr;
   logic        l2i_to_ifd_fill_en;
   logic [5:0]  l2i_to_ifd_fill_set_idx;
   logic [TW-1:0] l2i_to_ifd_fill_tag;
   logic        ifd_to_idata_rd_en;
   logic [5:0]  ifd_to_idata_rd_set_idx;
   logic [1:0]  ifd_to_idata_rd_way_idx;
   logic        dcd_allowin;
   logic        ifd_to_dcd_valid;
   logic [33:0] ifd_to_dcd_bus;
   logic        wb_rollback_en;
   logic [1:0]  wb_rollback_warp_idx;

   ifetch_data_stage dut (
      .clk(clk), .rst_n(rst_n),
      .ift_to_ifd_valid(ift_to_ifd_valid), .ift_to_ifd_bus(ift_to_ifd_bus),
      .ift_to_icache_fetch_en(ift_to_icache_fetch_en),
      .ift_to_icache_fetch_set_idx(ift_to_icache_fetch_set_idx),
      .ifd_allowin(ifd_allowin), .ifd_cache_miss(ifd_cache_miss), .ifd_near_miss(ifd_near_miss),
      .ifd_cache_miss_warp_idx(ifd_cache_miss_warp_idx),
      .ifd_to_l2i_miss_en(ifd_to_l2i_miss_en), .ifd_to_l2i_miss_addr(ifd_to_l2i_miss_addr),
      .l2i_to_ifd_fill_en(l2i_to_ifd_fill_en), .l2i_to_ifd_fill_set_idx(l2i_to_ifd_fill_set_idx),
      .l2i_to_ifd_fill_tag(l2i_to_ifd_fill_tag),
      .ifd_to_idata_rd_en(ifd_to_idata_rd_en), .ifd_to_idata_rd_set_idx(ifd_to_idata_rd_set_idx),
      .ifd_to_idata_rd_way_idx(ifd_to_idata_rd_way_idx),
      .dcd_allowin(dcd_allowin), .ifd_to_dcd_valid(ifd_to_dcd_valid), .ifd_to_dcd_bus(ifd_to_dcd_bus),
      .wb_rollback_en(wb_rollback_en), .wb_rollback_warp_idx(wb_rollback_warp_idx)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // cache model: which line lives in which way of each set, and the next victim
   bit          m_vld [64][4];
   logic [TW-1:0] m_tag [64][4];
   int          m_ptr [64];

   bit dv, nm, cm;
   int way;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int s = 0; s < 64; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < 4; w++) m_vld[s][w] = 1'b0;
      end
   endfunction

   function automatic void m_fill(input int s, input logic [TW-1:0] t);
      int w = m_ptr[s];
      m_vld[s][w] = 1'b1;
      m_tag[s][w] = t;
      m_ptr[s]    = (w + 1) % 4;
   endfunction

   function automatic int m_lookup(input int s, input logic [TW-1:0] t);
      for (int w = 0; w < 4; w++) if (m_vld[s][w] && m_tag[s][w] == t) return w;
      return -1;
   endfunction

   function automatic logic [31:0] mk_pc(input logic [TW-1:0] t, input int s, input logic [5:0] off);
      return {t, 6'(s), off};
   endfunction

   task automatic drive(input bit iv, input logic [31:0] pc, input logic [1:0] wp,
                        input bit fe, input int fs, input logic [TW-1:0] ft,
                        input bit rb, input logic [1:0] rw, input bit da);
      ift_to_ifd_valid            = iv;
      ift_to_ifd_bus              = {pc, wp};
      ift_to_icache_fetch_en      = iv;
      ift_to_icache_fetch_set_idx = pc[11:6];
      l2i_to_ifd_fill_en          = fe;
      l2i_to_ifd_fill_set_idx     = 6'(fs);
      l2i_to_ifd_fill_tag         = ft;
      wb_rollback_en              = rb;
      wb_rollback_warp_idx        = rw;
      dcd_allowin                 = da;
   endtask

   task automatic do_fill(input int s, input logic [TW-1:0] t);
      @(negedge clk);
      drive(1'b0, 32'h0, 2'd0, 1'b1, s, t, 1'b0, 2'd0, 1'b1);
      @(posedge clk);
      m_fill(s, t);
   endtask

   // One lookup: launch cycle (optional racing fill), evaluate cycle (optional fill, rollback, stall),
   // and one release cycle if a hit was held.
   task automatic do_txn(input logic [31:0] pc, input logic [1:0] wp,
                         input bit rf, input int rs, input logic [TW-1:0] rt,
                         input bit ef, input int es, input logic [TW-1:0] et,
                         input bit rb, input logic [1:0] rw, input bit da,
                         output bit o_dv, output bit o_nm, output bit o_cm, output int o_way);
      int            ps;
      logic [TW-1:0] pt;
      bit            ov [4];
      logic [TW-1:0] ot [4];
      bit            race;
      int            rway;
      int            hw;
      bit            fm, sq, e_dv, e_nm, e_cm;
      ps = int'(pc[11:6]);
      pt = pc[31:12];
      @(negedge clk);
      drive(1'b1, pc, wp, rf, rs, rt, 1'b0, 2'd0, 1'b1);
      #1 chk("launch_allowin", ifd_allowin, 1);
      for (int w = 0; w < 4; w++) begin
         ov[w] = m_vld[ps][w];
         ot[w] = m_tag[ps][w];
      end
      race = rf && (rs == ps);
      rway = m_ptr[rs];
      @(posedge clk);
      if (rf) m_fill(rs, rt);

      @(negedge clk);
      drive(1'b0, 32'h0, 2'd0, ef, es, et, rb, rw, da);
      #1;
      // lines present before the launch, minus any line being replaced by the racing fill
      hw = -1;
      for (int w = 0; w < 4; w++)
         if (hw < 0 && ov[w] && ot[w] == pt && !(race && w == rway)) hw = w;
      fm   = (ef && es == ps && et == pt) || (race && rt == pt);
      sq   = rb && (rw == wp);
      e_dv = (hw >= 0) && !sq;
      e_nm = (hw < 0) && fm && !sq;
      e_cm = (hw < 0) && !fm && !sq;
      chk("dcd_valid", ifd_to_dcd_valid, e_dv);
      chk("near_miss", ifd_near_miss, e_nm);
      chk("cache_miss", ifd_cache_miss, e_cm);
      chk("l2i_miss_en", ifd_to_l2i_miss_en, e_cm);
      chk("idata_rd_en", ifd_to_idata_rd_en, e_dv && da);
      chk("allowin", ifd_allowin, !e_dv || da);
      if (e_dv) begin
         chk("dcd_bus", ifd_to_dcd_bus, {pc, wp});
         chk("rd_set", ifd_to_idata_rd_set_idx, ps);
         chk("rd_way", ifd_to_idata_rd_way_idx, hw);
      end
      if (e_cm || e_nm) chk("miss_warp", ifd_cache_miss_warp_idx, wp);
      if (e_cm) chk("miss_addr", ifd_to_l2i_miss_addr, {pc[31:6], 6'd0});
      o_dv  = ifd_to_dcd_valid;
      o_nm  = ifd_near_miss;
      o_cm  = ifd_cache_miss;
      o_way = int'(ifd_to_idata_rd_way_idx);
      @(posedge clk);
      if (ef) m_fill(es, et);

      if (e_dv && !da) begin
         @(negedge clk);
         drive(1'b0, 32'h0, 2'd0, 1'b0, 0, '0, 1'b0, 2'd0, 1'b1);
         #1;
         hw = m_lookup(ps, pt);
         chk("held_dcd_valid", ifd_to_dcd_valid, hw >= 0);
         chk("held_cache_miss", ifd_cache_miss, hw < 0);
         if (hw >= 0) chk("held_rd_way", ifd_to_idata_rd_way_idx, hw);
         else chk("held_miss_addr", ifd_to_l2i_miss_addr, {pc[31:6], 6'd0});
         @(posedge clk);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_allowin"}, ifd_allowin, 1);
      chk({tag, "_dcd_valid"}, ifd_to_dcd_valid, 0);
      chk({tag, "_cache_miss"}, ifd_cache_miss, 0);
      chk({tag, "_near_miss"}, ifd_near_miss, 0);
      chk({tag, "_miss_en"}, ifd_to_l2i_miss_en, 0);
      chk({tag, "_miss_addr"}, ifd_to_l2i_miss_addr, 0);
      chk({tag, "_rd_en"}, ifd_to_idata_rd_en, 0);
      chk({tag, "_dcd_bus"}, ifd_to_dcd_bus, 0);
      chk({tag, "_miss_warp"}, ifd_cache_miss_warp_idx, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 2'd0, 1'b0, 0, '0, 1'b0, 2'd0, 1'b1);
      m_reset();
      #1 chk_idle_outputs("reset");
      chk("reset_rd_set", ifd_to_idata_rd_set_idx, 0);
      chk("reset_rd_way", ifd_to_idata_rd_way_idx, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // cold miss
      do_txn(32'h0000_1108, 2'd2, 0, 0, '0, 0, 0, '0, 0, 2'd0, 1, dv, nm, cm, way);
      chk("cold_miss", cm, 1);
      chk("cold_dv", dv, 0);

      // fill then hit
      do_fill(4, 20'h00000);
      do_txn(32'h0000_0104, 2'd1, 0, 0, '0, 0, 0, '0, 0, 2'd0, 1, dv, nm, cm, way);
      chk("fill_hit_dv", dv, 1);
      chk("fill_hit_way", way, 0);

      // fill races the launch on the same set with the looked-up tag
      do_txn(32'h0000_1104, 2'd0, 1, 4, 20'h00001, 0, 0, '0, 0, 2'd0, 1, dv, nm, cm, way);
      chk("race_near_miss", nm, 1);
      chk("race_not_miss", cm, 0);

      // rollback of the held warp
      do_txn(32'h0000_0104, 2'd3, 0, 0, '0, 0, 0, '0, 1, 2'd3, 1, dv, nm, cm, way);
      chk("rollback_dv", dv, 0);
      chk("rollback_nm", nm, 0);
      chk("rollback_cm", cm, 0);

      // stall a hit in way 0 while four fills cycle round to evict it
      do_fill(20, 20'h00005);
      @(negedge clk);
      drive(1'b1, mk_pc(20'h00005, 20, 6'h08), 2'd1, 1'b0, 0, '0, 1'b0, 2'd0, 1'b0);
      #1 chk("stall_launch_allowin", ifd_allowin, 1);
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(1'b0, 32'h0, 2'd0, 1'b1, 20, TW'(32'h100 + k), 1'b0, 2'd0, 1'b0);
         #1;
         chk("stall_hold_dv", ifd_to_dcd_valid, 1);
         chk("stall_hold_way", ifd_to_idata_rd_way_idx, 0);
         chk("stall_hold_allowin", ifd_allowin, 0);
         chk("stall_hold_miss", ifd_cache_miss, 0);
         @(posedge clk);
         m_fill(20, TW'(32'h100 + k));
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 2'd0, 1'b0, 0, '0, 1'b0, 2'd0, 1'b0);
      #1;
      chk("evict_miss", ifd_cache_miss, 1);
      chk("evict_dv", ifd_to_dcd_valid, 0);
      chk("evict_addr", ifd_to_l2i_miss_addr, 32'h0000_5500);
      chk("evict_warp", ifd_cache_miss_warp_idx, 1);
      chk("evict_allowin", ifd_allowin, 1);
      @(posedge clk);

      // five fills to set 9: ways 0,1,2,3,0, so the first line is gone and the pointer sits at 1
      for (int k = 0; k < 5; k++) do_fill(9, TW'(32'h90 + k));
      do_txn(mk_pc(20'h00094, 9, 6'h0), 2'd0, 0, 0, '0, 0, 0, '0, 0, 2'd0, 1, dv, nm, cm, way);
      chk("wrap_last_way", way, 0);
      chk("wrap_last_dv", dv, 1);
      do_txn(mk_pc(20'h00091, 9, 6'h4), 2'd1, 0, 0, '0, 0, 0, '0, 0, 2'd0, 1, dv, nm, cm, way);
      chk("wrap_second_way", way, 1);
      do_txn(mk_pc(20'h00090, 9, 6'h0), 2'd2, 0, 0, '0, 0, 0, '0, 0, 2'd0, 1, dv, nm, cm, way);
      chk("wrap_first_gone", cm, 1);
      do_fill(9, 20'h00095);
      do_txn(mk_pc(20'h00095, 9, 6'h0), 2'd3, 0, 0, '0, 0, 0, '0, 0, 2'd0, 1, dv, nm, cm, way);
      chk("wrap_next_way", way, 1);

      // reset in the middle of a held hit
      @(negedge clk);
      drive(1'b1, mk_pc(20'h00094, 9, 6'h0), 2'd2, 1'b0, 0, '0, 1'b0, 2'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 32'h0, 2'd0, 1'b0, 0, '0, 1'b0, 2'd0, 1'b0);
      #1 chk("pre_reset_dv", ifd_to_dcd_valid, 1);
      rst_n = 1'b0;
      #1 chk_idle_outputs("midreset");
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      m_reset();
      do_txn(mk_pc(20'h00094, 9, 6'h0), 2'd0, 0, 0, '0, 0, 0, '0, 0, 2'd0, 1, dv, nm, cm, way);
      chk("post_reset_miss", cm, 1);
      do_fill(9, 20'h00077);
      do_txn(mk_pc(20'h00077, 9, 6'h0), 2'd0, 0, 0, '0, 0, 0, '0, 0, 2'd0, 1, dv, nm, cm, way);
      chk("post_reset_ptr_way", way, 0);

      // randomized lookups over a few crowded sets
      for (int i = 0; i < 300; i++) begin
         int            s, rs, es;
         logic [TW-1:0] t, rt, et;
         bit            rf, ef, rb, da;
         logic [1:0]    wp, rw;
         if ($urandom_range(0, 2) == 0) do_fill($urandom_range(3, 5), TW'($urandom_range(0, 5)));
         s  = $urandom_range(3, 5);
         t  = TW'($urandom_range(0, 5));
         wp = 2'($urandom_range(0, 3));
         rf = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 1) == 0) ? s : $urandom_range(3, 5);
         rt = TW'($urandom_range(0, 5));
         ef = ($urandom_range(0, 3) == 0);
         es = ($urandom_range(0, 1) == 0) ? s : $urandom_range(3, 5);
         et = TW'($urandom_range(0, 5));
         rb = ($urandom_range(0, 5) == 0);
         rw = 2'($urandom_range(0, 3));
         da = ($urandom_range(0, 3) != 0);
         do_txn(mk_pc(t, s, 6'($urandom_range(0, 63))), wp, rf, rs, rt, ef, es, et, rb, rw, da,
                dv, nm, cm, way);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ifetch_data_stage.md
# ifetch_data_stage

Second instruction-fetch stage, directly downstream of the ifetch tag stage. Holds one lookup `{pc, warp_idx}` per cycle and compares the PC tag against a snapshot of the I-cache tag/valid set read at launch. On a hit it forwards the PC to decode and issues the I-cache data-array read. On a miss it reports the miss back to the tag stage, which rewinds and parks the warp, and issues a line request to the L2 interface. The block owns the tag/valid arrays and the per-set replacement pointers.

## Interface
Parameters (from `defines.vh`):
- `NUM_WARP_PER_CORE`, 4: warps per core; `_LOG` = log2.
- `ADDR_WIDTH`, 32: PC width.
- `L1_CACHE_NUM_SETS`, 64: sets; `_LOG` = log2.
- `L1_CACHE_NUM_WAYS`, 4: ways; `_LOG` = log2.
- `CACHE_LINE_BYTE_WIDTH_LOG`, 6: line is 64 B.
- `TAG_W`: `ADDR_WIDTH - L1_CACHE_NUM_SETS_LOG - CACHE_LINE_BYTE_WIDTH_LOG`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ift_to_ifd_valid` in 1: tag stage has a lookup.
- `ift_to_ifd_bus` in `ADDR_WIDTH+NUM_WARP_PER_CORE_LOG`: `{pc, warp_idx}`.
- `ift_to_icache_fetch_en` in 1: tag read enable.
- `ift_to_icache_fetch_set_idx` in `SETS_LOG`: set to read.
- `ifd_allowin` out 1: stage can accept a lookup.
- `ifd_cache_miss` out 1: true miss; the warp sleeps.
- `ifd_near_miss` out 1: miss racing a fill; the warp refetches without sleeping.
- `ifd_cache_miss_warp_idx` out `WARP_LOG`: warp of the miss or near miss.
- `ifd_to_l2i_miss_en` out 1: line request.
- `ifd_to_l2i_miss_addr` out `ADDR_WIDTH`: line-aligned PC.
- `l2i_to_ifd_fill_en` in 1: a line fill completes this cycle.
- `l2i_to_ifd_fill_set_idx` in `SETS_LOG`: set of the fill.
- `l2i_to_ifd_fill_tag` in `TAG_W`: tag of the fill.
- `ifd_to_idata_rd_en` out 1: data-array read.
- `ifd_to_idata_rd_set_idx` out `SETS_LOG`: set to read.
- `ifd_to_idata_rd_way_idx` out `WAYS_LOG`: way to read.
- `dcd_allowin` in 1: decode can accept.
- `ifd_to_dcd_valid` out 1: hit instruction to decode.
- `ifd_to_dcd_bus` out `ADDR_WIDTH+WARP_LOG`: `{pc, warp_idx}`.
- `wb_rollback_en` in 1: rollback request.
- `wb_rollback_warp_idx` in `WARP_LOG`: warp being rolled back.

## Operation
**Launch**
- launch = `ift_to_ifd_valid && ifd_allowin`.
- On launch, register `ifd_valid`, the bus, and a snapshot of all ways' `{valid, tag}` at `ift_to_icache_fetch_set_idx`.
- Snapshot read is read-old: a same-cycle fill is not visible.
- On launch, register `fill_race` = fill_en and fill set equals the launch set.

**Lookup**
- Each cycle while valid, a fill to the held set is written through into the snapshot.
- hit = any way with valid and tag equal to `pc[ADDR_WIDTH-1 -: TAG_W]`. If several match, the lowest way wins.
- fill_match = `fill_en && fill_set == pc set && fill_tag == pc tag`, or (`fill_race` registered and the same tag was filled in the launch cycle; keep a registered match bit).
- squash = `wb_rollback_en && wb_rollback_warp_idx == warp`.
- `ifd_to_dcd_valid` = valid & hit & ~squash.
- `ifd_near_miss` = valid & ~hit & fill_match & ~squash.
- `ifd_cache_miss` = valid & ~hit & ~fill_match & ~squash.
- `ifd_to_l2i_miss_en` = `ifd_cache_miss`.
- Miss address = `{pc[ADDR_WIDTH-1:LINE_LOG], 0}`.
- `ifd_cache_miss_warp_idx` = the held warp.
- Duplicate line requests from several warps are permitted; L2I merges them.

**Decode handshake and data read**
- `ifd_allowin` = `~ifd_valid | ~ifd_to_dcd_valid | dcd_allowin`.
- Miss, near-miss and squashed entries retire in one cycle regardless of decode.
- `ifd_to_idata_rd_en` = `ifd_to_dcd_valid && dcd_allowin`, with the hit way and set.

**Tag arrays and replacement**
- `valid[set][way]`, `tag[set][way]`, and a per-set round-robin `rr_ptr[set]`.
- On `fill_en`: write `valid=1` and `tag` at `rr_ptr[set]`, then advance the pointer modulo the way count (wraps `WAYS-1` to 0).

## Timing
- Reset clears `ifd_valid`, all valid bits, all `rr_ptr`, `fill_race` and the snapshot. All outputs read 0 except `ifd_allowin`, which reads 1.
- Lookup latency is 1 cycle: launched at T, evaluated at T+1.
- Miss and near-miss signals are combinational from the stage registers and current fill and rollback inputs. They pulse exactly one cycle per lookup.
- Held hit under a decode stall: if a fill evicts the matched line during the hold, the entry turns into `ifd_cache_miss` in the following cycle. Decode never receives a stale hit.
- Fill and lookup launch on the same set in the same cycle: the snapshot holds the old data, and a tag match reports `ifd_near_miss`.
- Rollback of the held warp during a stall drops the entry and produces no outputs.
- Reset asserted mid-operation drops the entry and invalidates the entire cache.

## Test plan
- Cold miss: after reset, launch `{0x0000_1108, w2}` → next cycle `ifd_cache_miss=1`, `warp_idx=2`, `miss_addr=0x0000_1100`, `dcd_valid=0`.
- Fill then hit: fill set 4, tag `0x00000` → way 0, `rr_ptr[4]=1`. Launch pc `0x0000_0104`, w1 → `dcd_valid=1`, `rd_en=1`, `set=4`, `way=0`.
- Near miss: fill set 4, tag `0x00001` in the same cycle as launching pc `0x0000_1104` → `ifd_near_miss=1`, `miss_en=0`.
- Rollback: hit entry for w3 with `wb_rollback_en=1`, `warp_idx=3` → `dcd_valid=0`, `rd_en=0`, `ifd_allowin=1`.
- Stall and evict: hit in way 0 with `dcd_allowin=0`. Four fills to the set replace way 0 → `ifd_cache_miss=1` one cycle after the evicting fill.
- Replacement wrap: five fills to set 9 → ways 0,1,2,3,0 written; `rr_ptr[9]=1`.
